// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   REG_ADDR_W         : register-file address width (x0..x31)
//   MD_TIMEOUT_DEFAULT : default cycle limit for one multi-cycle M-op
//   ctrl_state_e       : sequencer states
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned MD_TIMEOUT_DEFAULT = 64;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [0:0] {
    CTRL_RUN     = 1'b0,
    CTRL_MD_BUSY = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Load-use hazard compare between the load in EXE and the source operands in ID.
// Ports:
//   id_rs1_i / id_rs2_i       : source register addresses of the ID instruction
//   id_rs1_en_i / id_rs2_en_i : ID actually reads that source
//   exe_mem_read_i            : EXE instruction is a load
//   exe_rd_i                  : destination of the EXE instruction
//   luse_o                    : ID must wait one cycle for the load result
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_en_i,
  input  logic                  id_rs2_en_i,
  input  logic                  exe_mem_read_i,
  input  logic [REG_ADDR_W-1:0] exe_rd_i,
  output logic                  luse_o
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign rd_nonzero = (exe_rd_i != '0);
  assign rs1_hit    = id_rs1_en_i && (id_rs1_i == exe_rd_i);
  assign rs2_hit    = id_rs2_en_i && (id_rs2_i == exe_rd_i);
  assign luse_o     = exe_mem_read_i && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (pc, if_id, id_exe, exe_mem).
// Handles taken-branch flushes, multi-cycle M-ops, load-use bubbles and fetch wait states.
// Parameters:
//   MD_TIMEOUT : max MD_BUSY cycles before a forced release and sticky error
//   CNT_W      : width of the saturating stall-cycle counter
// Ports:
//   clk_i, rst_i (async, active-high)
//   id_rs1_i, id_rs2_i, id_rs1_en_i, id_rs2_en_i : ID operand usage
//   exe_mem_read_i, exe_rd_i                     : load in EXE
//   exe_br_taken_i                               : branch/jump taken in EXE
//   exe_md_op_i, md_done_i                       : M-op in EXE / M unit result valid
//   rom_ready_i                                  : instruction fetch data valid
//   pc_stall_o, if_id_stall_o, if_id_flush_o, id_exe_stall_o,
//   id_exe_flush_o, exe_mem_flush_o              : pipeline register controls
//   md_start_o                                   : one-cycle start pulse to M unit
//   md_err_o                                     : sticky M-op timeout flag
//   stall_cnt_o                                  : cycles with pc_stall_o high, saturating
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs1_en_i,
  input  logic                  id_rs2_en_i,
  input  logic                  exe_mem_read_i,
  input  logic [REG_ADDR_W-1:0] exe_rd_i,
  input  logic                  exe_br_taken_i,
  input  logic                  exe_md_op_i,
  input  logic                  md_done_i,
  input  logic                  rom_ready_i,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_exe_stall_o,
  output logic                  id_exe_flush_o,
  output logic                  exe_mem_flush_o,
  output logic                  md_start_o,
  output logic                  md_err_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  localparam int unsigned TO_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  ctrl_state_e       state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              md_err_q, md_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic luse;
  logic err_set;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic id_exe_stall_c, id_exe_flush_c, exe_mem_flush_c, md_start_c;

  hazard_detect u_hazard_detect (
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_rs1_en_i    (id_rs1_en_i),
    .id_rs2_en_i    (id_rs2_en_i),
    .exe_mem_read_i (exe_mem_read_i),
    .exe_rd_i       (exe_rd_i),
    .luse_o         (luse)
  );

  always_comb begin
    state_d         = state_q;
    to_cnt_d        = to_cnt_q;
    err_set         = 1'b0;
    pc_stall_c      = 1'b0;
    if_id_stall_c   = 1'b0;
    if_id_flush_c   = 1'b0;
    id_exe_stall_c  = 1'b0;
    id_exe_flush_c  = 1'b0;
    exe_mem_flush_c = 1'b0;
    md_start_c      = 1'b0;

    unique case (state_q)
      CTRL_RUN: begin
        to_cnt_d = '0;
        if (exe_br_taken_i) begin
          if_id_flush_c  = 1'b1;
          id_exe_flush_c = 1'b1;
        end else if (exe_md_op_i) begin
          md_start_c      = 1'b1;
          state_d         = CTRL_MD_BUSY;
          pc_stall_c      = 1'b1;
          if_id_stall_c   = 1'b1;
          id_exe_stall_c  = 1'b1;
          exe_mem_flush_c = 1'b1;
        end else begin
          // Load-use and fetch wait may coincide: the held IF/ID must not be flushed.
          pc_stall_c     = luse || !rom_ready_i;
          if_id_stall_c  = luse;
          if_id_flush_c  = !rom_ready_i && !luse;
          id_exe_flush_c = luse;
        end
      end

      CTRL_MD_BUSY: begin
        if (md_done_i) begin
          // Result is captured into EXE/MEM this cycle, so everything releases now.
          state_d  = CTRL_RUN;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = CTRL_RUN;
          to_cnt_d = '0;
          err_set  = 1'b1;
        end else begin
          pc_stall_c      = 1'b1;
          if_id_stall_c   = 1'b1;
          id_exe_stall_c  = 1'b1;
          exe_mem_flush_c = 1'b1;
          to_cnt_d        = to_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = CTRL_RUN;
        to_cnt_d = '0;
      end
    endcase
  end

  assign md_err_d    = md_err_q || err_set;
  assign stall_cnt_d = (pc_stall_c && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= CTRL_RUN;
      to_cnt_q    <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Combinational controls are forced low for the whole time reset is held.
  assign pc_stall_o      = pc_stall_c      && !rst_i;
  assign if_id_stall_o   = if_id_stall_c   && !rst_i;
  assign if_id_flush_o   = if_id_flush_c   && !rst_i;
  assign id_exe_stall_o  = id_exe_stall_c  && !rst_i;
  assign id_exe_flush_o  = id_exe_flush_c  && !rst_i;
  assign exe_mem_flush_o = exe_mem_flush_c && !rst_i;
  assign md_start_o      = md_start_c      && !rst_i;
  assign md_err_o        = md_err_q;
  assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs1_i, id_rs2_i, exe_rd_i;
  logic        id_rs1_en_i, id_rs2_en_i, exe_mem_read_i;
  logic        exe_br_taken_i, exe_md_op_i, md_done_i, rom_ready_i;
  logic        pc_stall_o, if_id_stall_o, if_id_flush_o, id_exe_stall_o;
  logic        id_exe_flush_o, exe_mem_flush_o, md_start_o, md_err_o;
  logic [31:0] stall_cnt_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  pipeline_ctrl #(.MD_TIMEOUT(64), .CNT_W(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_rs1_i        (id_rs1_i),
    .id_rs2_i        (id_rs2_i),
    .id_rs1_en_i     (id_rs1_en_i),
    .id_rs2_en_i     (id_rs2_en_i),
    .exe_mem_read_i  (exe_mem_read_i),
    .exe_rd_i        (exe_rd_i),
    .exe_br_taken_i  (exe_br_taken_i),
    .exe_md_op_i     (exe_md_op_i),
    .md_done_i       (md_done_i),
    .rom_ready_i     (rom_ready_i),
    .pc_stall_o      (pc_stall_o),
    .if_id_stall_o   (if_id_stall_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_exe_stall_o  (id_exe_stall_o),
    .id_exe_flush_o  (id_exe_flush_o),
    .exe_mem_flush_o (exe_mem_flush_o),
    .md_start_o      (md_start_o),
    .md_err_o        (md_err_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush, exe_mem_flush, md_start}
  logic [6:0] outs;
  assign outs = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_exe_stall_o,
                 id_exe_flush_o, exe_mem_flush_o, md_start_o};

  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_LUSE  = 7'b1100100;
  localparam logic [6:0] O_BR    = 7'b0010100;
  localparam logic [6:0] O_FETCH = 7'b1010000;
  localparam logic [6:0] O_START = 7'b1101011;
  localparam logic [6:0] O_BUSY  = 7'b1101010;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       en1, en2, mrd, br, rom;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; exe_rd_i = 5'd0;
    id_rs1_en_i = 1'b0; id_rs2_en_i = 1'b0; exe_mem_read_i = 1'b0;
    exe_br_taken_i = 1'b0; exe_md_op_i = 1'b0; md_done_i = 1'b0; rom_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"idle",          5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_NONE};
    vecs[1] = '{"luse_rs2",      5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, O_LUSE};
    vecs[2] = '{"luse_rd_x0",    5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, O_NONE};
    vecs[3] = '{"rs2_not_read",  5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_NONE};
    vecs[4] = '{"luse_rs1",      5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_LUSE};
    vecs[5] = '{"no_load_match", 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_NONE};
    vecs[6] = '{"br_over_luse",  5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, O_BR};
    vecs[7] = '{"br_over_fetch", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_BR};
    vecs[8] = '{"fetch_wait",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_FETCH};
    vecs[9] = '{"luse_and_fetch",5'd3, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_LUSE};

    // Reset: controls forced low even with stalling inputs present.
    idle_inputs();
    rom_ready_i = 1'b0;
    exe_md_op_i = 1'b1;
    rst_i = 1'b1;
    #1;
    check("reset_outs", 32'(outs), 32'(O_NONE));
    check("reset_cnt", stall_cnt_o, 32'd0);
    check("reset_err", 32'(md_err_o), 32'd0);
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b0;

    // RUN-state priority table.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      idle_inputs();
      id_rs1_i = vecs[i].rs1; id_rs2_i = vecs[i].rs2; exe_rd_i = vecs[i].rd;
      id_rs1_en_i = vecs[i].en1; id_rs2_en_i = vecs[i].en2;
      exe_mem_read_i = vecs[i].mrd; exe_br_taken_i = vecs[i].br; rom_ready_i = vecs[i].rom;
      #1;
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
    end

    // md_done in RUN has no effect; following fetch wait shows state is still RUN.
    @(negedge clk_i); idle_inputs(); md_done_i = 1'b1; #1;
    check("done_in_run", 32'(outs), 32'(O_NONE));
    @(negedge clk_i); idle_inputs(); rom_ready_i = 1'b0; #1;
    check("still_run", 32'(outs), 32'(O_FETCH));

    // DIV released by done: 1 start cycle + 32 busy cycles stalled, release on done cycle.
    do_reset();
    @(negedge clk_i); exe_md_op_i = 1'b1; #1;
    check("div_start", 32'(outs), 32'(O_START));
    for (int k = 0; k < 32; k++) begin
      @(negedge clk_i);
      exe_br_taken_i = (k == 5);
      rom_ready_i = (k != 6);
      #1;
      check("div_busy", 32'(outs), 32'(O_BUSY));
    end
    @(negedge clk_i); exe_br_taken_i = 1'b0; rom_ready_i = 1'b1; md_done_i = 1'b1; #1;
    check("div_done_release", 32'(outs), 32'(O_NONE));

    // Back-to-back M-op starts in the cycle after release, then times out.
    @(negedge clk_i); md_done_i = 1'b0; #1;
    check("div_cnt33", stall_cnt_o, 32'd33);
    check("b2b_start", 32'(outs), 32'(O_START));
    for (int k = 0; k < 63; k++) begin
      @(negedge clk_i); #1;
      check("to_busy", 32'(outs), 32'(O_BUSY));
    end
    @(negedge clk_i); #1;
    check("to_release", 32'(outs), 32'(O_NONE));
    check("to_err_not_yet", 32'(md_err_o), 32'd0);
    @(negedge clk_i); exe_md_op_i = 1'b0; #1;
    check("to_err_set", 32'(md_err_o), 32'd1);
    check("to_outs_idle", 32'(outs), 32'(O_NONE));
    check("to_cnt97", stall_cnt_o, 32'd97);
    repeat (5) @(negedge clk_i);
    #1;
    check("err_sticky", 32'(md_err_o), 32'd1);

    // Load-use held for 3 cycles while fetch waits: IF/ID held, never flushed.
    do_reset();
    #1;
    check("err_cleared", 32'(md_err_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      exe_mem_read_i = 1'b1; exe_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_en_i = 1'b1;
      rom_ready_i = 1'b0;
      #1;
      check("luse_fetch_hold", 32'(outs), 32'(O_LUSE));
    end
    @(negedge clk_i); idle_inputs(); id_rs2_i = 5'd5; id_rs2_en_i = 1'b1; #1;
    check("luse_cleared", 32'(outs), 32'(O_NONE));
    check("luse_cnt3", stall_cnt_o, 32'd3);

    // Reset asserted in MD_BUSY cycle 10.
    @(negedge clk_i); idle_inputs(); exe_md_op_i = 1'b1;
    for (int k = 0; k < 10; k++) @(negedge clk_i);
    #1;
    check("busy_before_rst", 32'(outs), 32'(O_BUSY));
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_outs", 32'(outs), 32'(O_NONE));
    check("rst_async_cnt", stall_cnt_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; exe_md_op_i = 1'b0; rom_ready_i = 1'b0;
    #1;
    check("run_after_rst", 32'(outs), 32'(O_FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
